// File: rtl/mips_ppl_pkg.sv
// Shared constants for the MIPS pipeline: requester indices and default
// register-bank widths used by the write-port arbiter.
package mips_ppl_pkg;

    localparam int REQ_ALU        = 0;
    localparam int REQ_LOAD       = 1;
    localparam int REQ_MULDIV     = 2;

    localparam int B_REG_DEFAULT  = 32;
    localparam int B_SEL_DEFAULT  = 5;
    localparam int N_REQ_DEFAULT  = 3;

    // Pointer width for an nReq-entry round-robin ring (never zero bits).
    function automatic int ptrWidth(input int nReq);
        return (nReq > 1) ? $clog2(nReq) : 1;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first valid index
// at or after the pointer, wrapping from nREQ-1 back to 0.
module rr_picker
    import mips_ppl_pkg::*;
#(
    parameter int nREQ = N_REQ_DEFAULT,
    parameter int bPTR = ptrWidth(N_REQ_DEFAULT)
) (
    input  logic [nREQ-1:0] valid,
    input  logic [bPTR-1:0] pointer,
    output logic [nREQ-1:0] grant
);

    always_comb begin
        automatic int idx;
        automatic logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < nREQ; k++) begin
            idx = int'(pointer) + k;
            if (idx >= nREQ) idx = idx - nREQ;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter in front of the register-bank write port.
// Optional per-requester grant counters: define REGBANK_ARB_STATS_EN.
module regbank_write_arbiter
    import mips_ppl_pkg::*;
#(
    parameter int bREG = B_REG_DEFAULT,
    parameter int bSEL = B_SEL_DEFAULT,
    parameter int nREQ = N_REQ_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [nREQ-1:0]      req_valid,
    input  logic [nREQ*bSEL-1:0] req_sel,
    input  logic [nREQ*bREG-1:0] req_data,
    output logic [nREQ-1:0]      req_ready,
    input  logic                 flush,
    output logic                 enWriteReg,
    output logic [bSEL-1:0]      selWriteReg,
    output logic [bREG-1:0]      WriteData
`ifdef REGBANK_ARB_STATS_EN
    ,
    output logic [nREQ*16-1:0]   grant_count
`endif
);

    localparam int bPTR = ptrWidth(nREQ);

    logic [bPTR-1:0] rrPtr;
    logic [bPTR-1:0] rrNext;
    logic [nREQ-1:0] grant;
    logic [bPTR-1:0] grantIdx;
    logic [bSEL-1:0] grantSel;
    logic [bREG-1:0] grantData;
    logic            xfer;

    rr_picker #(
        .nREQ (nREQ),
        .bPTR (bPTR)
    ) picker (
        .valid   (req_valid),
        .pointer (rrPtr),
        .grant   (grant)
    );

    // Reset and flush both mask the grant so nothing transfers in those cycles.
    assign req_ready = (reset && !flush) ? grant : '0;
    assign xfer      = |req_ready;

    always_comb begin
        grantIdx  = '0;
        grantSel  = '0;
        grantData = '0;
        for (int i = 0; i < nREQ; i++) begin
            if (grant[i]) begin
                grantIdx  = bPTR'(i);
                grantSel  = req_sel[i*bSEL +: bSEL];
                grantData = req_data[i*bREG +: bREG];
            end
        end
    end

    assign rrNext = (grantIdx == bPTR'(nREQ - 1)) ? '0 : grantIdx + bPTR'(1);

    // Writes to register 0 are consumed but never reach the bank.
    always_ff @(posedge clock) begin
        if (!reset) begin
            enWriteReg  <= 1'b0;
            selWriteReg <= '0;
            WriteData   <= '0;
            rrPtr       <= '0;
        end else begin
            enWriteReg <= 1'b0;
            if (xfer) begin
                rrPtr <= rrNext;
                if (grantSel != '0) begin
                    enWriteReg  <= 1'b1;
                    selWriteReg <= grantSel;
                    WriteData   <= grantData;
                end
            end
        end
    end

`ifdef REGBANK_ARB_STATS_EN
    logic [15:0] grantCnt [nREQ];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < nREQ; i++) grantCnt[i] <= '0;
        end else begin
            for (int i = 0; i < nREQ; i++) begin
                if (req_ready[i] && grantCnt[i] != 16'hFFFF)
                    grantCnt[i] <= grantCnt[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < nREQ; g++) begin : gCount
        assign grant_count[g*16 +: 16] = grantCnt[g];
    end
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench for regbank_write_arbiter: stimulus queues the expected
// write-port value, a monitor pops and compares it after every clock edge.
module tb_regbank_write_arbiter;

    typedef struct packed {
        logic        en;
        logic [4:0]  sel;
        logic [31:0] data;
    } outRec_t;

    logic        clock;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_sel;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        flush;
    logic        enWriteReg;
    logic [4:0]  selWriteReg;
    logic [31:0] WriteData;
`ifdef REGBANK_ARB_STATS_EN
    logic [47:0] grant_count;
`endif

    outRec_t expQ[$];
    int      errors = 0;
    int      checks = 0;

    regbank_write_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .flush       (flush),
        .enWriteReg  (enWriteReg),
        .selWriteReg (selWriteReg),
        .WriteData   (WriteData)
`ifdef REGBANK_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Monitor: the write port is compared once per cycle after the edge.
    always @(posedge clock) begin
        outRec_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (enWriteReg !== e.en || selWriteReg !== e.sel || WriteData !== e.data) begin
                errors++;
                $display("FAIL wport: got en=%b sel=%0d data=%h expected en=%b sel=%0d data=%h",
                         enWriteReg, selWriteReg, WriteData, e.en, e.sel, e.data);
            end
        end
    end

    function automatic logic [14:0] ps(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2);
        return {s2, s1, s0};
    endfunction

    function automatic logic [95:0] pd(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        return {d2, d1, d0};
    endfunction

    task automatic step(input logic rstN, input logic fl, input logic [2:0] v,
                        input logic [14:0] s, input logic [95:0] d,
                        input logic [2:0] expRdy, input logic expEn,
                        input logic [4:0] expSel, input logic [31:0] expData);
        outRec_t r;
        @(negedge clock);
        reset     = rstN;
        flush     = fl;
        req_valid = v;
        req_sel   = s;
        req_data  = d;
        #1;
        checks++;
        if (req_ready !== expRdy) begin
            errors++;
            $display("FAIL ready: got %b expected %b (valid=%b flush=%b reset=%b)",
                     req_ready, expRdy, v, fl, rstN);
        end
        r.en   = expEn;
        r.sel  = expSel;
        r.data = expData;
        expQ.push_back(r);
    endtask

    initial begin
        logic [14:0] s123;
        logic [95:0] dAll;
        reset     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_sel   = '0;
        req_data  = '0;
        s123 = ps(5'd1, 5'd2, 5'd3);
        dAll = pd(32'h1111_0000, 32'h2222_0001, 32'h3333_0002);

        // Reset holds ready low even with all requesters valid.
        step(0, 0, 3'b111, s123, dAll, 3'b000, 0, 5'd0, 32'h0);
        step(0, 0, 3'b000, '0, '0, 3'b000, 0, 5'd0, 32'h0);

        // Single ALU write.
        step(1, 0, 3'b001, ps(5'd5, 5'd0, 5'd0), pd(32'hDEADBEEF, 0, 0), 3'b001, 1, 5'd5, 32'hDEADBEEF);
        step(1, 0, 3'b000, '0, '0, 3'b000, 0, 5'd5, 32'hDEADBEEF);

        // Requester 2 moves rr_ptr back to 0.
        step(1, 0, 3'b100, ps(5'd0, 5'd0, 5'd7), pd(0, 0, 32'h0000_0022), 3'b100, 1, 5'd7, 32'h0000_0022);

        // All valid for six cycles from rr_ptr = 0.
        step(1, 0, 3'b111, s123, dAll, 3'b001, 1, 5'd1, 32'h1111_0000);
        step(1, 0, 3'b111, s123, dAll, 3'b010, 1, 5'd2, 32'h2222_0001);
        step(1, 0, 3'b111, s123, dAll, 3'b100, 1, 5'd3, 32'h3333_0002);
        step(1, 0, 3'b111, s123, dAll, 3'b001, 1, 5'd1, 32'h1111_0000);
        step(1, 0, 3'b111, s123, dAll, 3'b010, 1, 5'd2, 32'h2222_0001);
        step(1, 0, 3'b111, s123, dAll, 3'b100, 1, 5'd3, 32'h3333_0002);

        // Register 0 write from load: accepted, not written; rr_ptr -> 2.
        step(1, 0, 3'b010, ps(5'd0, 5'd0, 5'd0), pd(0, 32'hCAFEF00D, 0), 3'b010, 0, 5'd3, 32'h3333_0002);

        // Flush blocks everything and holds rr_ptr at 2.
        step(1, 1, 3'b111, ps(5'd1, 5'd2, 5'd9), pd(32'h1111_0000, 32'h2222_0001, 32'h9999_0009),
             3'b000, 0, 5'd3, 32'h3333_0002);
        step(1, 0, 3'b111, ps(5'd1, 5'd2, 5'd9), pd(32'h1111_0000, 32'h2222_0001, 32'h9999_0009),
             3'b100, 1, 5'd9, 32'h9999_0009);
        // Flush right after a grant does not suppress that registered write.
        step(1, 1, 3'b111, s123, dAll, 3'b000, 0, 5'd9, 32'h9999_0009);

        // Transfer then reset with a load request pending; it goes out once after release.
        step(1, 0, 3'b001, ps(5'd4, 5'd0, 5'd0), pd(32'h0000_4444, 0, 0), 3'b001, 1, 5'd4, 32'h0000_4444);
        step(0, 0, 3'b010, ps(5'd0, 5'd6, 5'd0), pd(0, 32'h0000_6666, 0), 3'b000, 0, 5'd0, 32'h0);
        step(0, 0, 3'b010, ps(5'd0, 5'd6, 5'd0), pd(0, 32'h0000_6666, 0), 3'b000, 0, 5'd0, 32'h0);
        step(1, 0, 3'b010, ps(5'd0, 5'd6, 5'd0), pd(0, 32'h0000_6666, 0), 3'b010, 1, 5'd6, 32'h0000_6666);
        step(1, 0, 3'b000, '0, '0, 3'b000, 0, 5'd6, 32'h0000_6666);

`ifdef REGBANK_ARB_STATS_EN
        step(0, 0, 3'b000, '0, '0, 3'b000, 0, 5'd0, 32'h0);
        @(posedge clock);
        #2;
        checks++;
        if (grant_count !== 48'h0) begin
            errors++;
            $display("FAIL count_reset: got %h expected %h", grant_count, 48'h0);
        end
        for (int n = 0; n < 70000; n++)
            step(1, 0, 3'b100, ps(5'd0, 5'd0, 5'd1), pd(0, 0, 32'h0000_00AA), 3'b100, 1, 5'd1, 32'h0000_00AA);
        @(posedge clock);
        #2;
        checks++;
        if (grant_count !== 48'hFFFF_0000_0000) begin
            errors++;
            $display("FAIL count_sat: got %h expected %h", grant_count, 48'hFFFF_0000_0000);
        end
`endif

        req_valid = '0;
        for (int w = 0; w < 5 && expQ.size() > 0; w++) @(posedge clock);
        #3;
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
